fifo_ctrl: RTL and testbench

Sequencing controller for the 8-entry × 15-bit dual-port memory: owns write/read pointers, occupancy, full/empty flags and the memory's `wren`/`wradder`/`radder`/`data` inputs. It turns the raw memory into a first-in, first-out queue with push/pop handshakes. After reset it zero-fills all eight entries before accepting traffic. It sits between the operand/result producer and consumer and the memory instance, and is the only driver of the memory's write and address ports.

---
 rtl/fifo_ctrl_if.sv | 73 +++++++
 rtl/fifo_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fifo_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_if
//
// Purpose: bundles the user-facing push/pop handshake of the FIFO sequencing
// controller so that producer/consumer logic and the controller share one
// port.
//
// Signals:
//   push       write request
//   push_data  word to enqueue (WIDTH bits)
//   pop        read request
//   flush      discard contents (pointers to zero, memory untouched)
//   ready      controller has finished zero-filling and accepts requests
//   full       occupancy equals DEPTH
//   empty      occupancy equals zero
//   count      occupancy, 0..DEPTH (4 bits)
//   rd_data    dequeued word, qualified by rd_valid
//   rd_valid   rd_data holds the word from the pop accepted last cycle
//   overflow   sticky push-while-full flag (zero unless error tracking built)
//   underflow  sticky pop-while-empty flag (zero unless error tracking built)
//
// Modports:
//   master  producer/consumer side (drives requests, observes status)
//   slave   controller side (observes requests, drives status)
// ---------------------------------------------------------------------------
interface fifo_ctrl_if #(
  parameter int WIDTH = 15
);

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             flush;
  logic             ready;
  logic             full;
  logic             empty;
  logic [3:0]       count;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             overflow;
  logic             underflow;

  modport master (
    output push,
    output push_data,
    output pop,
    output flush,
    input  ready,
    input  full,
    input  empty,
    input  count,
    input  rd_data,
    input  rd_valid,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  push,
    input  push_data,
    input  pop,
    input  flush,
    output ready,
    output full,
    output empty,
    output count,
    output rd_data,
    output rd_valid,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//
// Purpose: sequencing controller that turns an 8-entry x 15-bit dual-port
// memory (registered read, read-old-data on a same-address write) into a
// first-in, first-out queue. It owns the write/read pointers, occupancy and
// the full/empty flags, and is the only driver of the memory's write and
// address ports. After reset it zero-fills every entry before it raises
// ready and accepts traffic.
//
// Parameters:
//   DEPTH  memory entries, power of two in {2,4,8} (address ports are 4 bits)
//   WIDTH  data width
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (restarts the zero-fill)
//   bus          fifo_ctrl_if.slave: push/pop/flush handshake and status
//   mem_data     to memory data
//   mem_wradder  to memory wradder
//   mem_radder   to memory radder
//   mem_wren     to memory wren
//   mem_q        from memory q (1-cycle registered read)
//
// Build option:
//   FIFO_CTRL_ERR_EN  when defined, overflow/underflow become sticky error
//                     registers cleared by rst or flush; otherwise both
//                     outputs are tied low and no flag registers exist.
// ---------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  fifo_ctrl_if.slave       bus,
  output logic [WIDTH-1:0] mem_data,
  output logic [3:0]       mem_wradder,
  output logic [3:0]       mem_radder,
  output logic             mem_wren,
  input  logic [WIDTH-1:0] mem_q
);

  // Index width for the memory, plus one wrap bit for the pointers so that
  // full and empty are distinguishable when the low bits match.
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clrIdx_q, clrIdx_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic            rdValid_q, rdValid_d;

  logic [PW-1:0]   occupancy;
  logic            readyInt;
  logic            fullInt;
  logic            emptyInt;
  logic            pushAcc;
  logic            popAcc;

  // Status is derived purely from the pointers, so it follows the accepting
  // edge by one cycle without any extra registers.
  assign occupancy = wrPtr_q - rdPtr_q;
  assign fullInt   = (occupancy == PW'(DEPTH));
  assign emptyInt  = (occupancy == '0);
  assign readyInt  = (state_q == RUN);

  // Flush wins over both requests. A push on a full queue is still taken
  // when a pop frees a slot in the same cycle; the memory returns the old
  // word for the read, so no bypass is needed. A pop on an empty queue is
  // never taken, even alongside a push, because the word is not yet stored.
  assign popAcc  = readyInt & bus.pop & ~bus.flush & ~emptyInt;
  assign pushAcc = readyInt & bus.push & ~bus.flush & (~fullInt | popAcc);

  assign bus.ready    = readyInt;
  assign bus.full     = fullInt;
  assign bus.empty    = emptyInt;
  assign bus.count    = 4'(occupancy);
  assign bus.rd_valid = rdValid_q;
  assign bus.rd_data  = mem_q;

  // The read address always tracks the read pointer, so the word at the
  // head is already being fetched when a pop is accepted.
  assign mem_radder = 4'(rdPtr_q[AW-1:0]);

  // Next-state and memory-port logic. CLEAR walks every address writing
  // zero; RUN forwards accepted pushes to the memory and advances the
  // pointers.
  always_comb begin
    state_d     = state_q;
    clrIdx_d    = clrIdx_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    rdValid_d   = popAcc;
    mem_wren    = 1'b0;
    mem_wradder = 4'(wrPtr_q[AW-1:0]);
    mem_data    = bus.push_data;

    case (state_q)
      CLEAR: begin
        mem_wren    = 1'b1;
        mem_wradder = 4'(clrIdx_q);
        mem_data    = '0;
        clrIdx_d    = clrIdx_q + 1'b1;
        if (clrIdx_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.flush) begin
          wrPtr_d   = '0;
          rdPtr_d   = '0;
          rdValid_d = 1'b0;
        end else begin
          mem_wren = pushAcc;
          if (pushAcc) begin
            wrPtr_d = wrPtr_q + 1'b1;
          end
          if (popAcc) begin
            rdPtr_d = rdPtr_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // State register. Reset restarts the zero-fill and drops any pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clrIdx_q  <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clrIdx_q  <= clrIdx_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      rdValid_q <= rdValid_d;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error capture. A push on full that is rescued by a same-cycle pop
  // is not an overflow. Flush clears both flags and takes priority.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (readyInt && bus.flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (bus.push && readyInt && fullInt && !popAcc) begin
        overflow_d = 1'b1;
      end
      if (bus.pop && readyInt && emptyInt) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Error flag registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl
//
// Purpose: self-checking bench for fifo_ctrl. A behavioural dual-port memory
// (registered read, read-old-data) sits on the memory ports. Directed steps
// drive the handshake; each accepted pop pushes its expected word into a
// scoreboard queue, and an independent monitor compares every rd_valid beat
// against that queue. Status flags are compared after every step against a
// small queue model and, at key points, against hand-written constants.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

  localparam int WIDTH = 15;
  localparam int DEPTH = 8;
`ifdef FIFO_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

  logic [WIDTH-1:0] memData;
  logic [WIDTH-1:0] memQ;
  logic [3:0]       memWradder;
  logic [3:0]       memRadder;
  logic             memWren;

  fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_data    (memData),
    .mem_wradder (memWradder),
    .mem_radder  (memRadder),
    .mem_wren    (memWren),
    .mem_q       (memQ)
  );

  // Behavioural memory: the read samples the array before the write lands,
  // giving read-old-data on a same-address collision.
  logic [WIDTH-1:0] memArray [0:DEPTH-1];

  always @(posedge clk) begin
    if (memWren) memArray[memWradder[2:0]] <= memData;
    memQ <= memArray[memRadder[2:0]];
  end

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] modelQ[$];
  bit               modelOvf = 1'b0;
  bit               modelUnf = 1'b0;
  logic [WIDTH-1:0] expWord;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: an expected word is queued just after the edge that
  // accepted the pop, so it must be presented at this same negedge.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL rd_valid_unexpected actual=1 expected=0");
      end else begin
        expWord = expQ.pop_front();
        if (bus.rd_data !== expWord) begin
          errors++;
          $display("[TB] FAIL rd_data actual=%0h expected=%0h", bus.rd_data, expWord);
        end
      end
    end else if (expQ.size() > 0) begin
      checks++;
      errors++;
      expWord = expQ.pop_front();
      $display("[TB] FAIL rd_valid_missing actual=0 expected=1 (word %0h)", expWord);
    end
  end

  task automatic checkStatus();
    checkOutput("count", bus.count, modelQ.size());
    checkOutput("full", bus.full, modelQ.size() == DEPTH);
    checkOutput("empty", bus.empty, modelQ.size() == 0);
    checkOutput("overflow", bus.overflow, modelOvf);
    checkOutput("underflow", bus.underflow, modelUnf);
  endtask

  // One RUN-mode cycle: drive the request, predict acceptance from the
  // queue model, check the memory write enable, then clock it in.
  task automatic applyStimulus(input bit ps, input logic [WIDTH-1:0] d,
                               input bit pp, input bit fl);
    bit popOk;
    bit pushOk;
    logic [WIDTH-1:0] popWord;
    int sz;
    bus.push      = ps;
    bus.push_data = d;
    bus.pop       = pp;
    bus.flush     = fl;
    sz      = modelQ.size();
    popOk   = 1'b0;
    pushOk  = 1'b0;
    popWord = '0;
    if (fl) begin
      modelQ.delete();
      modelOvf = 1'b0;
      modelUnf = 1'b0;
    end else begin
      popOk  = pp && (sz > 0);
      pushOk = ps && ((sz < DEPTH) || popOk);
      if (ERR_EN && ps && (sz == DEPTH) && !popOk) modelOvf = 1'b1;
      if (ERR_EN && pp && (sz == 0)) modelUnf = 1'b1;
      if (popOk) popWord = modelQ.pop_front();
      if (pushOk) modelQ.push_back(d);
    end
    #1;
    checkOutput("mem_wren", memWren, pushOk);
    @(posedge clk);
    #1;
    if (popOk) expQ.push_back(popWord);
    bus.push      = 1'b0;
    bus.push_data = '0;
    bus.pop       = 1'b0;
    bus.flush     = 1'b0;
    checkStatus();
  endtask

  // Reset (optionally with a pop pending at the reset edge), then walk the
  // eight zero-fill cycles with requests held active to show they are ignored.
  task automatic resetAndClear(input bit popDuringReset);
    bus.pop = popDuringReset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.pop = 1'b0;
    modelQ.delete();
    modelOvf = 1'b0;
    modelUnf = 1'b0;
    checkOutput("rst_ready", bus.ready, 0);
    checkOutput("rst_rd_valid", bus.rd_valid, 0);
    checkStatus();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.push      = 1'b1;
      bus.push_data = 15'h1234;
      bus.pop       = 1'b1;
      #1;
      checkOutput("clr_ready", bus.ready, 0);
      checkOutput("clr_wren", memWren, 1);
      checkOutput("clr_wradder", memWradder, i);
      checkOutput("clr_data", memData, 0);
      @(posedge clk);
      #1;
    end
    bus.push      = 1'b0;
    bus.push_data = '0;
    bus.pop       = 1'b0;
    #1;
    checkOutput("run_ready", bus.ready, 1);
    checkOutput("run_count", bus.count, 0);
    checkOutput("run_empty", bus.empty, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.push      = 1'b0;
    bus.push_data = '0;
    bus.pop       = 1'b0;
    bus.flush     = 1'b0;
    for (int i = 0; i < DEPTH; i++) memArray[i] = 15'h5555;
    @(posedge clk);
    #1;
    resetAndClear(1'b0);

    // Fill 1..8, then drain in order.
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b0);
    checkOutput("fill_count", bus.count, 8);
    checkOutput("fill_full", bus.full, 1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("drain_empty", bus.empty, 1);

    // Push and pop together on full: oldest word comes out, count holds.
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, WIDTH'(16 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 15'h7FFF, 1'b1, 1'b0);
    checkOutput("fullpp_count", bus.count, 8);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("fullpp_empty", bus.empty, 1);

    // Push and pop together on empty: pop rejected, push taken.
    applyStimulus(1'b1, 15'h0AAA, 1'b1, 1'b0);
    checkOutput("emptypp_count", bus.count, 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Steady three-entry stream across pointer wrap.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'(256 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, WIDTH'(259 + i), 1'b1, 1'b0);
      checkOutput("wrap_count", bus.count, 3);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Error flags, then flush clearing everything.
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("underflow_set", bus.underflow, ERR_EN);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, WIDTH'(512 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 15'h0BAD, 1'b0, 1'b0);
    checkOutput("overflow_set", bus.overflow, ERR_EN);
    checkOutput("overflow_count", bus.count, 8);
    applyStimulus(1'b1, 15'h0BEE, 1'b1, 1'b1);
    checkOutput("flush_count", bus.count, 0);
    checkOutput("flush_overflow", bus.overflow, 0);
    checkOutput("flush_underflow", bus.underflow, 0);
    applyStimulus(1'b1, 15'h0055, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Reset in RUN with a pop at the reset edge: nothing comes out.
    applyStimulus(1'b1, 15'h0101, 1'b0, 1'b0);
    applyStimulus(1'b1, 15'h0102, 1'b0, 1'b0);
    resetAndClear(1'b1);
    applyStimulus(1'b1, 15'h0303, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
